// File: rtl/cfg_serial_arbiter_pkg.sv
// cfg_serial_arbiter_pkg
//   Shared definitions for the serial configuration arbiter family.
//   - state_t            : 2-bit FSM encoding (IDLE, LAUNCH, WAIT, COMPLETE)
//   - DEF_DATA_WIDTH     : default shifter word width
//   - DEF_TIMEOUT_CYCLES : default watchdog limit (0 disables it)
//   - DEF_CNT_WIDTH      : default watchdog counter width
package cfg_serial_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LAUNCH   = 2'd1,
        ST_WAIT     = 2'd2,
        ST_COMPLETE = 2'd3
    } state_t;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 4096;
    localparam int DEF_CNT_WIDTH      = 13;

endpackage

// File: rtl/cfg_serial_arbiter_rr_priority_pick.sv
// rr_priority_pick
//   Combinational round-robin pick: searches req upward from ptr, wrapping
//   modulo NUM_REQ, and reports the first set requester.
//   Ports:
//     req        in  NUM_REQ  request vector
//     ptr        in  IDX_W    highest-priority index this round
//     winner_oh  out NUM_REQ  one-hot winner (0 when no request)
//     winner_idx out IDX_W    winner index (0 when no request)
//     valid      out 1        at least one request present
module rr_priority_pick
    import cfg_serial_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner_oh,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               valid
);

    // Outer loop walks priority order (ptr, ptr+1, ...); inner loop matches
    // that position against a constant index so every select is static.
    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        valid      = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!valid && req[i] && (i == (int'(ptr) + off) % NUM_REQ)) begin
                    valid        = 1'b1;
                    winner_oh[i] = 1'b1;
                    winner_idx   = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/cfg_serial_arbiter.sv
// cfg_serial_arbiter
//   Shares one serial configuration shifter between NUM_REQ command sources.
//   Round-robin grant, one DATA_WIDTH word per grant, per-requester ack and
//   watchdog timeout pulses. All outputs are registered.
//   Handshake: req[i] is a level held until req_ack[i]; the requester drops
//   req or changes its word on the edge that samples req_ack. The shifter
//   sees a one-cycle start_transaction with parallel_output already stable
//   and answers with a one-cycle transaction_done.
//   Ports:
//     clk, reset_n         clock, async active-low reset
//     enable               gates new grants only
//     req, req_data        level requests and flattened words
//     req_ack, req_timeout one-cycle completion / watchdog-expiry pulses
//     grant                one-hot, held LAUNCH..WAIT
//     busy                 high outside IDLE
//     start_transaction    launch pulse to the shifter
//     parallel_output      latched word to the shifter
//     transaction_done     completion pulse from the shifter
//     state_dbg            current FSM state
module cfg_serial_arbiter
    import cfg_serial_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [NUM_REQ-1:0]            req_timeout,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic                          start_transaction,
    output logic [DATA_WIDTH-1:0]         parallel_output,
    input  logic                          transaction_done,
    output logic [1:0]                    state_dbg
);

    localparam int IDX_W = $clog2(NUM_REQ);
    // Last count value before expiry; unused when the watchdog is disabled.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       win_q, win_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0]     grant_d, ack_d, timeout_d;
    logic                   start_d, busy_d;
    logic [DATA_WIDTH-1:0]  pout_d;

    logic [NUM_REQ-1:0]     pick_oh;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;
    logic [DATA_WIDTH-1:0]  words [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign words[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_priority_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req        (req),
        .ptr        (ptr_q),
        .winner_oh  (pick_oh),
        .winner_idx (pick_idx),
        .valid      (pick_valid)
    );

    assign state_dbg = state_q;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        grant_d   = grant;
        ack_d     = '0;
        timeout_d = '0;
        start_d   = 1'b0;
        pout_d    = parallel_output;
        case (state_q)
            ST_IDLE: begin
                if (enable && pick_valid) begin
                    state_d = ST_LAUNCH;
                    grant_d = pick_oh;
                    win_d   = pick_idx;
                    pout_d  = words[pick_idx];
                    start_d = 1'b1;
                end
            end
            ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // Done is checked first so it wins over a same-cycle expiry.
                if (transaction_done) begin
                    state_d = ST_COMPLETE;
                    grant_d = '0;
                    ack_d   = grant;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    state_d   = ST_COMPLETE;
                    grant_d   = '0;
                    ack_d     = grant;
                    timeout_d = grant;
                end
            end
            ST_COMPLETE: begin
                state_d = ST_IDLE;
                ptr_d   = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= ST_IDLE;
            ptr_q             <= '0;
            win_q             <= '0;
            cnt_q             <= '0;
            grant             <= '0;
            req_ack           <= '0;
            req_timeout       <= '0;
            start_transaction <= 1'b0;
            busy              <= 1'b0;
            parallel_output   <= '0;
        end else begin
            state_q           <= state_d;
            ptr_q             <= ptr_d;
            win_q             <= win_d;
            cnt_q             <= cnt_d;
            grant             <= grant_d;
            req_ack           <= ack_d;
            req_timeout       <= timeout_d;
            start_transaction <= start_d;
            busy              <= busy_d;
            parallel_output   <= pout_d;
        end
    end

endmodule

// File: tb/tb_cfg_serial_arbiter.sv
// Directed bench for cfg_serial_arbiter with a 16-cycle watchdog.
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled there too, so every check sees the values registered at that edge.
module tb_cfg_serial_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;

    localparam logic [31:0] S_IDLE = 32'd0;
    localparam logic [31:0] S_LAUNCH = 32'd1;
    localparam logic [31:0] S_WAIT = 32'd2;
    localparam logic [31:0] S_COMPLETE = 32'd3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            enable;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ack, req_timeout, grant;
    logic            busy, start_transaction;
    logic [DW-1:0]   parallel_output;
    logic            transaction_done;
    logic [1:0]      state_dbg;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic [DW-1:0] words [N];
    logic [N-1:0]  exp_q [$];

    cfg_serial_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16), .CNT_WIDTH(5)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .enable            (enable),
        .req               (req),
        .req_data          (req_data),
        .req_ack           (req_ack),
        .req_timeout       (req_timeout),
        .grant             (grant),
        .busy              (busy),
        .start_transaction (start_transaction),
        .parallel_output   (parallel_output),
        .transaction_done  (transaction_done),
        .state_dbg         (state_dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #100000;
        $display("FAIL sim_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pack_words();
        req_data = {words[2], words[1], words[0]};
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'h0);
        chk({tag, "_ack"}, 32'(req_ack), 32'h0);
        chk({tag, "_tmo"}, 32'(req_timeout), 32'h0);
        chk({tag, "_start"}, 32'(start_transaction), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_pout"}, parallel_output, 32'h0);
        chk({tag, "_state"}, 32'(state_dbg), S_IDLE);
    endtask

    initial begin
        logic [N-1:0] exp_g;
        int           wi;
        int           last_launch;

        reset_n          = 1'b0;
        enable           = 1'b0;
        req              = '0;
        transaction_done = 1'b0;
        words[0] = 32'h0;
        words[1] = 32'h0;
        words[2] = 32'h0;
        pack_words();
        repeat (2) tick();
        chk_all_zero("reset");

        // Single requester, done ignored in LAUNCH, req/data changes in WAIT
        reset_n  = 1'b1;
        enable   = 1'b1;
        req      = 3'b001;
        words[0] = 32'hA5A5_0001;
        pack_words();
        tick();
        chk("t1_start", 32'(start_transaction), 32'h1);
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_pout", parallel_output, 32'hA5A5_0001);
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_state_launch", 32'(state_dbg), S_LAUNCH);
        transaction_done = 1'b1;
        tick();
        transaction_done = 1'b0;
        chk("t1_done_in_launch_state", 32'(state_dbg), S_WAIT);
        chk("t1_done_in_launch_ack", 32'(req_ack), 32'h0);
        chk("t1_start_cleared", 32'(start_transaction), 32'h0);
        req      = 3'b000;
        words[0] = 32'hDEAD_BEEF;
        pack_words();
        repeat (7) tick();
        chk("t1_pout_latched", parallel_output, 32'hA5A5_0001);
        chk("t1_grant_held", 32'(grant), 32'h1);
        chk("t1_no_early_ack", 32'(req_ack), 32'h0);
        transaction_done = 1'b1;
        tick();
        transaction_done = 1'b0;
        chk("t1_ack", 32'(req_ack), 32'h1);
        chk("t1_tmo", 32'(req_timeout), 32'h0);
        chk("t1_grant_clear", 32'(grant), 32'h0);
        chk("t1_state_complete", 32'(state_dbg), S_COMPLETE);
        tick();
        chk("t1_ack_pulse", 32'(req_ack), 32'h0);
        chk("t1_busy_drop", 32'(busy), 32'h0);
        transaction_done = 1'b1;
        tick();
        transaction_done = 1'b0;
        chk("idle_spurious_done_state", 32'(state_dbg), S_IDLE);
        chk("idle_spurious_done_start", 32'(start_transaction), 32'h0);

        // All requesters: strict rotation from pointer 0, 4-cycle spacing
        reset_n = 1'b0;
        #1;
        reset_n  = 1'b1;
        words[0] = 32'h1111_0000;
        words[1] = 32'h2222_0000;
        words[2] = 32'h3333_0000;
        pack_words();
        req = 3'b111;
        exp_q = '{3'b001, 3'b010, 3'b100, 3'b001};
        last_launch = -1;
        for (int t = 0; t < 4; t++) begin
            exp_g = exp_q.pop_front();
            wi = (exp_g == 3'b001) ? 0 : (exp_g == 3'b010) ? 1 : 2;
            tick();
            chk("rr_grant", 32'(grant), 32'(exp_g));
            chk("rr_start", 32'(start_transaction), 32'h1);
            chk("rr_pout", parallel_output, words[wi]);
            if (last_launch >= 0)
                chk("rr_spacing", 32'(cyc - last_launch), 32'd4);
            last_launch = cyc;
            tick();
            transaction_done = 1'b1;
            tick();
            transaction_done = 1'b0;
            chk("rr_ack", 32'(req_ack), 32'(exp_g));
            words[wi] = words[wi] + 32'h1;
            pack_words();
            if (t == 3) req = 3'b000;
            tick();
        end

        // Watchdog expiry: requester 1 (pointer now 1)
        req = 3'b010;
        tick();
        chk("tmo_grant", 32'(grant), 32'h2);
        chk("tmo_pout", parallel_output, 32'h2222_0001);
        tick();
        repeat (15) tick();
        chk("tmo_not_yet_ack", 32'(req_ack), 32'h0);
        chk("tmo_not_yet_state", 32'(state_dbg), S_WAIT);
        tick();
        chk("tmo_ack", 32'(req_ack), 32'h2);
        chk("tmo_flag", 32'(req_timeout), 32'h2);
        chk("tmo_grant_clear", 32'(grant), 32'h0);
        req = 3'b110;
        tick();
        tick();
        chk("tmo_next_grant", 32'(grant), 32'h4);

        // Done coincident with the last watchdog count: done wins
        tick();
        repeat (15) tick();
        transaction_done = 1'b1;
        tick();
        transaction_done = 1'b0;
        chk("race_ack", 32'(req_ack), 32'h4);
        chk("race_tmo", 32'(req_timeout), 32'h0);
        req = 3'b000;
        tick();

        // enable gating
        enable = 1'b0;
        req    = 3'b010;
        tick();
        tick();
        chk("en_off_grant", 32'(grant), 32'h0);
        chk("en_off_busy", 32'(busy), 32'h0);
        enable = 1'b1;
        tick();
        chk("en_on_grant", 32'(grant), 32'h2);
        chk("en_on_start", 32'(start_transaction), 32'h1);
        tick();
        enable = 1'b0;
        tick();
        tick();
        transaction_done = 1'b1;
        tick();
        transaction_done = 1'b0;
        chk("en_fall_ack", 32'(req_ack), 32'h2);
        repeat (3) tick();
        chk("en_hold_grant", 32'(grant), 32'h0);
        chk("en_hold_busy", 32'(busy), 32'h0);
        chk("en_hold_state", 32'(state_dbg), S_IDLE);

        // Async reset during WAIT
        enable = 1'b1;
        tick();
        chk("rw_grant", 32'(grant), 32'h2);
        tick();
        chk("rw_state_wait", 32'(state_dbg), S_WAIT);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("rw_async");
        tick();
        chk("rw_no_ack", 32'(req_ack), 32'h0);
        reset_n = 1'b1;
        req     = 3'b100;
        tick();
        chk("rw_after_grant", 32'(grant), 32'h4);
        chk("rw_after_start", 32'(start_transaction), 32'h1);
        chk("rw_after_pout", parallel_output, 32'h3333_0001);

        // final report
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
